// File: rtl/lifting_step_row.sv
// One lifting step of a 1-D wavelet row transform, Channels lanes sharing one handshake.
// Predict mode holds one pair so it can see the right neighbour; Update mode remembers the previous odd.
//   state    | meaning
//   ST_IDLE  | no pair held, start of a line
//   ST_HOLD  | one pair held, waiting for its right neighbour
//   ST_FLUSH | eol pair held, input stalled until it is emitted
module lifting_step_row #(
   parameter int    Channels = 1,
   parameter int    Width    = 16,
   parameter int    Point    = 12,
   parameter string Mode     = "Predict",
   parameter real   K        = -1.586134342,
   parameter int    KWidth   = 16,
   parameter int    KPoint   = 13
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      s_valid,
   output logic                      s_ready,
   input  logic                      s_sof,
   input  logic                      s_eol,
   input  logic [Channels*Width-1:0] s_even,
   input  logic [Channels*Width-1:0] s_odd,
   output logic                      m_valid,
   input  logic                      m_ready,
   output logic                      m_sof,
   output logic                      m_eol,
   output logic [Channels*Width-1:0] m_even,
   output logic [Channels*Width-1:0] m_odd
);
   localparam int CW      = Channels * Width;
   localparam int PW      = Width + KWidth + 1;
   localparam bit IS_PRED = (Mode == "Predict");
   localparam int KQ_I    = int'(K * (2.0 ** KPoint));
   localparam logic signed [KWidth-1:0] KQ      = KWidth'(KQ_I);
   localparam logic signed [PW-1:0]     RND     = PW'(1) << (KPoint - 1);
   localparam logic signed [PW:0]       SAT_MAX = ((PW+1)'(1) << (Width - 1)) - (PW+1)'(1);
   localparam logic signed [PW:0]       SAT_MIN = -((PW+1)'(1) << (Width - 1));

   if (KQ_I > (2 ** (KWidth - 1)) - 1 || KQ_I < -(2 ** (KWidth - 1))) begin : g_kq_check
      $error("lifting_step_row: K quantises to %0d, outside signed %0d-bit range", KQ_I, KWidth);
   end
   if (Mode != "Predict" && Mode != "Update") begin : g_mode_check
      $error("lifting_step_row: Mode must be Predict or Update");
   end
   if (KPoint < 1 || Point >= Width) begin : g_fmt_check
      $error("lifting_step_row: unsupported fixed-point format");
   end

   typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_FLUSH} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   hold_even_q, hold_even_d, hold_odd_q, hold_odd_d, prev_odd_q, prev_odd_d;
   logic            hold_sof_q, hold_sof_d, line_start_q, line_start_d;
   logic            m_valid_q, m_valid_d, m_sof_q, m_sof_d, m_eol_q, m_eol_d;
   logic [CW-1:0]   m_even_q, m_even_d, m_odd_q, m_odd_d;
   logic [CW-1:0]   pred_nb, pred_odd, upd_prev, upd_even;
   logic            out_free, accept;

   // base + round(Kq*(a+b) / 2^KPoint), saturated to the sample range
   function automatic logic [Width-1:0] lift(input logic signed [Width-1:0] base,
                                             input logic signed [Width-1:0] a,
                                             input logic signed [Width-1:0] b);
      logic signed [Width:0] sum;
      logic signed [PW-1:0]  prod;
      logic signed [PW-1:0]  t;
      logic signed [PW:0]    r;
      sum  = (Width+1)'(a) + (Width+1)'(b);
      prod = PW'(sum) * PW'(KQ);
      t    = (prod + RND) >>> KPoint;
      r    = (PW+1)'(base) + (PW+1)'(t);
      if (r > SAT_MAX)      lift = SAT_MAX[Width-1:0];
      else if (r < SAT_MIN) lift = SAT_MIN[Width-1:0];
      else                  lift = r[Width-1:0];
   endfunction

   assign out_free = !m_valid_q || m_ready;
   assign s_ready  = !rst && out_free && (state_q != ST_FLUSH);
   assign accept   = s_valid && s_ready;

   // the eol pair mirrors itself as right neighbour; a line's first pair mirrors its own odd
   assign pred_nb  = (state_q == ST_FLUSH) ? hold_even_q : s_even;
   assign upd_prev = (line_start_q || s_sof) ? s_odd : prev_odd_q;

   always_comb begin
      pred_odd = '0;
      upd_even = '0;
      for (int c = 0; c < Channels; c++) begin
         pred_odd[c*Width +: Width] = lift(hold_odd_q[c*Width +: Width],
                                           hold_even_q[c*Width +: Width],
                                           pred_nb[c*Width +: Width]);
         upd_even[c*Width +: Width] = lift(s_even[c*Width +: Width],
                                           upd_prev[c*Width +: Width],
                                           s_odd[c*Width +: Width]);
      end
   end

   always_comb begin
      state_d      = state_q;
      hold_even_d  = hold_even_q;
      hold_odd_d   = hold_odd_q;
      hold_sof_d   = hold_sof_q;
      prev_odd_d   = prev_odd_q;
      line_start_d = line_start_q;
      m_valid_d    = m_valid_q;
      m_sof_d      = m_sof_q;
      m_eol_d      = m_eol_q;
      m_even_d     = m_even_q;
      m_odd_d      = m_odd_q;
      if (out_free) m_valid_d = 1'b0;
      if (IS_PRED) begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  hold_even_d = s_even;
                  hold_odd_d  = s_odd;
                  hold_sof_d  = s_sof;
                  state_d     = s_eol ? ST_FLUSH : ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (accept) begin
                  m_valid_d   = 1'b1;
                  m_even_d    = hold_even_q;
                  m_odd_d     = pred_odd;
                  m_sof_d     = hold_sof_q;
                  m_eol_d     = 1'b0;
                  hold_even_d = s_even;
                  hold_odd_d  = s_odd;
                  hold_sof_d  = s_sof;
                  state_d     = s_eol ? ST_FLUSH : ST_HOLD;
               end
            end
            ST_FLUSH: begin
               if (out_free) begin
                  m_valid_d = 1'b1;
                  m_even_d  = hold_even_q;
                  m_odd_d   = pred_odd;
                  m_sof_d   = hold_sof_q;
                  m_eol_d   = 1'b1;
                  state_d   = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end else if (accept) begin
         m_valid_d    = 1'b1;
         m_even_d     = upd_even;
         m_odd_d      = s_odd;
         m_sof_d      = s_sof;
         m_eol_d      = s_eol;
         prev_odd_d   = s_odd;
         line_start_d = s_eol;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         hold_even_q  <= '0;
         hold_odd_q   <= '0;
         hold_sof_q   <= 1'b0;
         prev_odd_q   <= '0;
         line_start_q <= 1'b1;
         m_valid_q    <= 1'b0;
         m_sof_q      <= 1'b0;
         m_eol_q      <= 1'b0;
         m_even_q     <= '0;
         m_odd_q      <= '0;
      end else begin
         state_q      <= state_d;
         hold_even_q  <= hold_even_d;
         hold_odd_q   <= hold_odd_d;
         hold_sof_q   <= hold_sof_d;
         prev_odd_q   <= prev_odd_d;
         line_start_q <= line_start_d;
         m_valid_q    <= m_valid_d;
         m_sof_q      <= m_sof_d;
         m_eol_q      <= m_eol_d;
         m_even_q     <= m_even_d;
         m_odd_q      <= m_odd_d;
      end
   end

   assign m_valid = m_valid_q;
   assign m_sof   = m_sof_q;
   assign m_eol   = m_eol_q;
   assign m_even  = m_even_q;
   assign m_odd   = m_odd_q;
endmodule

// File: tb/tb_lifting_step_row.sv
// Scoreboard bench: a Predict (K=0.5) and an Update (K=0.25) instance, two lanes each,
// checked against a whole-line arithmetic model.
`timescale 1ns/1ps
module tb_lifting_step_row;
   localparam int     CH   = 2;
   localparam int     W    = 16;
   localparam int     CW   = CH * W;
   localparam longint KQ_P = 4096;
   localparam longint KQ_U = 2048;

   typedef struct packed {
      logic [CW-1:0] even;
      logic [CW-1:0] odd;
      logic          sof;
      logic          eol;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          s_valid[2], s_ready[2], s_sof[2], s_eol[2];
   logic          m_valid[2], m_ready[2], m_sof[2], m_eol[2];
   logic [CW-1:0] s_even[2], s_odd[2], m_even[2], m_odd[2];

   exp_t exp_p[$];
   exp_t exp_u[$];
   int   checks = 0;
   int   failures = 0;
   int   ev[64][2];
   int   od[64][2];
   bit   mv_seen[64];
   int   line_stalls;
   int   stall = 0;
   bit   rand_bp = 0;
   bit   gaps = 0;

   always #5 clk = ~clk;

   lifting_step_row #(.Channels(CH), .Width(W), .Point(12), .Mode("Predict"), .K(0.5),
                      .KWidth(16), .KPoint(13)) u_pred (
      .clk(clk), .rst(rst), .s_valid(s_valid[0]), .s_ready(s_ready[0]), .s_sof(s_sof[0]),
      .s_eol(s_eol[0]), .s_even(s_even[0]), .s_odd(s_odd[0]), .m_valid(m_valid[0]),
      .m_ready(m_ready[0]), .m_sof(m_sof[0]), .m_eol(m_eol[0]), .m_even(m_even[0]),
      .m_odd(m_odd[0]));

   lifting_step_row #(.Channels(CH), .Width(W), .Point(12), .Mode("Update"), .K(0.25),
                      .KWidth(16), .KPoint(13)) u_upd (
      .clk(clk), .rst(rst), .s_valid(s_valid[1]), .s_ready(s_ready[1]), .s_sof(s_sof[1]),
      .s_eol(s_eol[1]), .s_even(s_even[1]), .s_odd(s_odd[1]), .m_valid(m_valid[1]),
      .m_ready(m_ready[1]), .m_sof(m_sof[1]), .m_eol(m_eol[1]), .m_even(m_even[1]),
      .m_odd(m_odd[1]));

   function automatic int sat16(input longint v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return int'(v);
   endfunction

   // base + K*(a+b) in Q13 coefficient arithmetic, rounded half up
   function automatic int lift_ref(input int base, input int a, input int b, input longint kq);
      longint p;
      longint t;
      p = longint'(a + b) * kq;
      t = (p + 4096) >>> 13;
      return sat16(longint'(base) + t);
   endfunction

   function automatic logic [CW-1:0] pack2(input int v0, input int v1);
      logic [15:0] l0;
      logic [15:0] l1;
      l0 = v0[15:0];
      l1 = v1[15:0];
      return {l1, l0};
   endfunction

   task automatic check(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic send(input int d, input logic [CW-1:0] e, input logic [CW-1:0] o,
                       input bit sof, input bit eol, output int stalls, output bit mvs);
      bit acc;
      int cyc;
      acc = 0;
      cyc = 0;
      stalls = 0;
      mvs = 0;
      s_valid[d] = 1'b1;
      s_even[d]  = e;
      s_odd[d]   = o;
      s_sof[d]   = sof;
      s_eol[d]   = eol;
      while (!acc && cyc < 200) begin
         @(negedge clk);
         if (cyc == 0) mvs = m_valid[d];
         acc = s_ready[d];
         if (!acc) stalls++;
         @(posedge clk);
         #1;
         cyc++;
      end
      s_valid[d] = 1'b0;
      s_sof[d]   = 1'b0;
      s_eol[d]   = 1'b0;
      if (!acc) begin
         checks++;
         failures++;
         $display("FAIL send_timeout dut=%0d actual=not_accepted required=accepted", d);
      end
   endtask

   // Expected outputs for a whole line are queued before any of it is driven.
   task automatic issue_line(input int d, input int n, input bit sof, input bit eol, input int n_out);
      exp_t e;
      int   eo[2];
      int   oo[2];
      int   nb;
      int   pa;
      int   st;
      bit   mvs;
      for (int i = 0; i < n_out; i++) begin
         for (int c = 0; c < CH; c++) begin
            if (d == 0) begin
               nb    = (i + 1 < n) ? ev[i+1][c] : ev[i][c];
               eo[c] = ev[i][c];
               oo[c] = lift_ref(od[i][c], ev[i][c], nb, KQ_P);
            end else begin
               pa    = (i == 0) ? od[0][c] : od[i-1][c];
               eo[c] = lift_ref(ev[i][c], pa, od[i][c], KQ_U);
               oo[c] = od[i][c];
            end
         end
         e.even = pack2(eo[0], eo[1]);
         e.odd  = pack2(oo[0], oo[1]);
         e.sof  = sof && (i == 0);
         e.eol  = eol && (i == n - 1);
         if (d == 0) exp_p.push_back(e);
         else        exp_u.push_back(e);
      end
      line_stalls = 0;
      for (int i = 0; i < n; i++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
         send(d, pack2(ev[i][0], ev[i][1]), pack2(od[i][0], od[i][1]),
              sof && (i == 0), eol && (i == n - 1), st, mvs);
         line_stalls += st;
         mv_seen[i] = mvs;
      end
   endtask

   task automatic fill_random(input int n);
      for (int i = 0; i < n; i++)
         for (int c = 0; c < CH; c++) begin
            ev[i][c] = int'($urandom_range(0, 65535)) - 32768;
            od[i][c] = int'($urandom_range(0, 65535)) - 32768;
         end
   endtask

   task automatic chk_rst(input int d);
      check($sformatf("rst_m_valid_%0d", d), m_valid[d], 0);
      check($sformatf("rst_s_ready_%0d", d), s_ready[d], 0);
      check($sformatf("rst_m_flags_%0d", d), {m_sof[d], m_eol[d]}, 0);
      check($sformatf("rst_m_data_%0d", d), (m_even[d] != '0 || m_odd[d] != '0) ? 1 : 0, 0);
   endtask

   task automatic drain();
      for (int k = 0; k < 2000 && (exp_p.size() != 0 || exp_u.size() != 0); k++) @(posedge clk);
      @(posedge clk);
      #1;
      check("drain_empty", exp_p.size() + exp_u.size(), 0);
   endtask

   initial begin
      m_ready[0] = 1'b1;
      m_ready[1] = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         for (int d = 0; d < 2; d++)
            m_ready[d] = (stall > 0) ? 1'b0 : (rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1);
         if (stall > 0) stall--;
      end
   end

   always @(negedge clk) begin : mon
      exp_t e;
      bit   empty;
      for (int d = 0; d < 2; d++) begin
         if (!rst && m_valid[d] && m_ready[d]) begin
            checks++;
            empty = (d == 0) ? (exp_p.size() == 0) : (exp_u.size() == 0);
            if (empty) begin
               failures++;
               $display("FAIL unexpected_output dut=%0d actual even=%h odd=%h required=none",
                        d, m_even[d], m_odd[d]);
            end else begin
               if (d == 0) e = exp_p.pop_front();
               else        e = exp_u.pop_front();
               if ({m_even[d], m_odd[d], m_sof[d], m_eol[d]} !== {e.even, e.odd, e.sof, e.eol}) begin
                  failures++;
                  $display("FAIL out_pair dut=%0d actual even=%h odd=%h sof=%0b eol=%0b required even=%h odd=%h sof=%0b eol=%0b",
                           d, m_even[d], m_odd[d], m_sof[d], m_eol[d], e.even, e.odd, e.sof, e.eol);
               end
            end
         end
      end
   end

   initial begin
      bit next_sof;
      bit sof;
      bit eol;
      int n;
      for (int d = 0; d < 2; d++) begin
         s_valid[d] = 1'b0;
         s_sof[d]   = 1'b0;
         s_eol[d]   = 1'b0;
         s_even[d]  = '0;
         s_odd[d]   = '0;
      end
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_rst(0);
      chk_rst(1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_rst_p", s_ready[0], 1);
      check("ready_after_rst_u", s_ready[1], 1);
      @(posedge clk);
      #1;

      // Predict two-pair line: held pair emitted only after the eol pair, one stall cycle
      ev[0] = '{4096, 1000};  od[0] = '{2048, -3000};
      ev[1] = '{8192, -500};  od[1] = '{1024, 700};
      issue_line(0, 2, 1, 1, 2);
      check("pred_no_early_out", mv_seen[1], 0);
      check("pred_no_stall_in_line", line_stalls, 0);
      @(negedge clk);
      check("pred_flush_valid", m_valid[0], 1);
      check("pred_flush_ready_low", s_ready[0], 0);
      check("pred_odd0", m_odd[0][15:0], 16'h2000);
      @(negedge clk);
      check("pred_odd1", m_odd[0][15:0], 16'h2400);
      check("pred_eol1", m_eol[0], 1);
      check("pred_ready_back", s_ready[0], 1);
      @(posedge clk);
      #1;

      // Update two-pair line: one-cycle latency, no bubbles
      ev[0] = '{4096, -2000}; od[0] = '{8192, 300};
      ev[1] = '{4096, 50};    od[1] = '{16384, -9000};
      issue_line(1, 2, 1, 1, 2);
      check("upd_latency", mv_seen[1], 1);
      check("upd_no_bubble", line_stalls, 0);
      @(negedge clk);
      check("upd_even1", m_even[1][15:0], 16'h2800);
      @(posedge clk);
      #1;

      // Saturation: lane 0 positive, lane 1 negative
      ev[0] = '{16384, -16384}; od[0] = '{28672, -28672};
      ev[1] = '{16384, -16384}; od[1] = '{0, 0};
      issue_line(0, 2, 0, 1, 2);
      @(negedge clk);
      check("sat_both_lanes", m_odd[0], 32'h8000_7FFF);
      @(posedge clk);
      #1;

      // One-pair lines use both extensions
      for (int d = 0; d < 2; d++) begin
         fill_random(1);
         issue_line(d, 1, 1, 1, 1);
      end
      drain();

      // 3-cycle output stall in the middle of a 16-pair line
      for (int d = 0; d < 2; d++) begin
         fill_random(16);
         fork
            issue_line(d, 16, 1, 1, 16);
            begin
               repeat (6) @(posedge clk);
               #2;
               stall = 3;
            end
         join
      end
      drain();

      // Reset after pair 5 of a line: nothing more from it, next line clean
      for (int d = 0; d < 2; d++) begin
         fill_random(5);
         issue_line(d, 5, 1, 0, (d == 0) ? 4 : 5);
         @(negedge clk);
         @(posedge clk);
         #1;
         rst = 1'b1;
         @(posedge clk);
         @(negedge clk);
         chk_rst(d);
         check($sformatf("rst_mid_queue_%0d", d), (d == 0) ? exp_p.size() : exp_u.size(), 0);
         @(posedge clk);
         #1;
         rst = 1'b0;
         fill_random(6);
         issue_line(d, 6, 0, 1, 6);
      end
      drain();

      // Random lines with random backpressure and input gaps
      rand_bp = 1;
      gaps = 1;
      for (int d = 0; d < 2; d++) begin
         next_sof = 1;
         for (int ln = 0; ln < 10; ln++) begin
            n = $urandom_range(1, 9);
            sof = next_sof || ($urandom_range(0, 3) == 0);
            eol = (d == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
            next_sof = !eol;
            fill_random(n);
            issue_line(d, n, sof, eol, n);
         end
      end
      rand_bp = 0;
      gaps = 0;
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
